// File: rtl/scan_decoder_pkg.sv
// Shared types and helpers for the scanning one-hot decoder.
package scan_decoder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_t;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Prescaler counter width: enough bits to hold PRESC-1, never less than one.
  function automatic int unsigned presc_w(input int unsigned p);
    return (p <= 32'd1) ? 32'd1 : 32'($clog2(p));
  endfunction

endpackage

// File: rtl/onehot_dec.sv
// Combinational binary-to-one-hot decoder with enable and output polarity.
module onehot_dec #(
  parameter int unsigned N = 2
) (
  input  logic [N-1:0]    sel,
  input  logic            en,
  input  logic            hl,
  output logic [2**N-1:0] dec_c
);

  localparam int unsigned W = 2**N;

  // Selected bit drives the active level (hl), every other bit the inactive level.
  for (genvar g = 0; g < W; g++) begin : g_bit
    assign dec_c[g] = (en && (sel == N'(g))) ? hl : ~hl;
  end

endmodule

// File: rtl/scan_decoder.sv
// Registered decoder: direct decode of a select input or a timed scan over 0..limit.
module scan_decoder
  import scan_decoder_pkg::*;
#(
  parameter int unsigned N     = 2,
  parameter int unsigned PRESC = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            hl,
  input  logic            mode,
  input  logic [N-1:0]    in,
  input  logic [N-1:0]    limit,
  output logic [2**N-1:0] out,
  output logic [N-1:0]    idx,
  output logic            wrap
);

  localparam int unsigned W          = 2**N;
  localparam int unsigned PW         = presc_w(PRESC);
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC - 1);

  state_t          state_q;
  state_t          state_d;
  logic [PW-1:0]   presc_q;
  logic [PW-1:0]   presc_d;
  logic [N-1:0]    idx_d;
  logic            wrap_d;
  logic            dec_en_c;
  logic [W-1:0]    dec_c;

  // Single decoder shared by the direct and scan paths; it sees the next index.
  onehot_dec #(
    .N(N)
  ) u_dec (
    .sel  (idx_d),
    .en   (dec_en_c),
    .hl   (hl),
    .dec_c(dec_c)
  );

  // State, prescaler and all outputs are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      presc_q <= '0;
      idx     <= '0;
      wrap    <= 1'b0;
      out     <= '0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      idx     <= idx_d;
      wrap    <= wrap_d;
      out     <= dec_c;
    end
  end

  // Next state from en/mode every cycle; next index, prescaler and wrap per state.
  always_comb begin
    state_d  = IDLE;
    presc_d  = '0;
    idx_d    = idx;
    wrap_d   = 1'b0;
    if (en) begin
      state_d = (mode == MODE_SCAN) ? SCAN : DIRECT;
    end
    case (state_d)
      DIRECT: begin
        idx_d = in;
      end
      SCAN: begin
        if (state_q != SCAN) begin
          // Entry restarts the scan at index 0 with a fresh dwell.
          idx_d = '0;
        end else if (presc_q == PRESC_LAST) begin
          // A lowered limit still wraps cleanly because the test is >=.
          if (idx >= limit) begin
            idx_d  = '0;
            wrap_d = 1'b1;
          end else begin
            idx_d = idx + N'(1);
          end
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
      default: begin
      end
    endcase
    dec_en_c = (state_d != IDLE);
  end

endmodule

// File: tb/tb_scan_decoder.sv
// Self-checking bench: two decoder configurations against a behavioural model.
module tb_scan_decoder;

  localparam int unsigned NA = 2;
  localparam int unsigned PA = 3;
  localparam int unsigned NB = 3;
  localparam int unsigned PB = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic hl = 1'b0;
  logic mode = 1'b0;
  logic [NA-1:0] in_a = '0;
  logic [NA-1:0] limit_a = '0;
  logic [NB-1:0] in_b = '0;
  logic [NB-1:0] limit_b = '0;

  logic [3:0] out_a;
  logic [1:0] idx_a;
  logic       wrap_a;
  logic [7:0] out_b;
  logic [2:0] idx_b;
  logic       wrap_b;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  scan_decoder #(.N(NA), .PRESC(PA)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .hl(hl), .mode(mode),
    .in(in_a), .limit(limit_a), .out(out_a), .idx(idx_a), .wrap(wrap_a)
  );

  scan_decoder #(.N(NB), .PRESC(PB)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .hl(hl), .mode(mode),
    .in(in_b), .limit(limit_b), .out(out_b), .idx(idx_b), .wrap(wrap_b)
  );

  // Behavioural view: which index is shown, how long it has been shown, whether scanning.
  typedef struct {
    int idx;
    int dwell;
    bit scanning;
    int out;
    bit wrap;
  } m_t;

  m_t m_a;
  m_t m_b;

  function automatic int pattern(input int k, input bit act_hi, input bit on, input int n);
    int mask;
    int oh;
    mask = (1 << (1 << n)) - 1;
    oh   = on ? (1 << k) : 0;
    return act_hi ? oh : (~oh & mask);
  endfunction

  function automatic m_t model_reset();
    m_t r;
    r.idx = 0; r.dwell = 0; r.scanning = 1'b0; r.out = 0; r.wrap = 1'b0;
    return r;
  endfunction

  function automatic m_t model_step(input m_t m, input int n, input int presc,
                                    input bit e, input bit md, input bit h,
                                    input int sel, input int lim);
    m_t r;
    r = m;
    r.wrap = 1'b0;
    r.dwell = 0;
    if (!e) begin
      r.scanning = 1'b0;
      r.out = pattern(0, h, 1'b0, n);
    end else if (!md) begin
      r.scanning = 1'b0;
      r.idx = sel;
      r.out = pattern(sel, h, 1'b1, n);
    end else if (!m.scanning) begin
      r.scanning = 1'b1;
      r.idx = 0;
      r.out = pattern(0, h, 1'b1, n);
    end else begin
      if (m.dwell + 1 >= presc) begin
        if (m.idx >= lim) begin
          r.idx = 0;
          r.wrap = 1'b1;
        end else begin
          r.idx = m.idx + 1;
        end
      end else begin
        r.dwell = m.dwell + 1;
      end
      r.out = pattern(r.idx, h, 1'b1, n);
    end
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_a <= model_reset();
      m_b <= model_reset();
    end else begin
      m_a <= model_step(m_a, NA, PA, en, mode, hl, 32'(in_a), 32'(limit_a));
      m_b <= model_step(m_b, NB, PB, en, mode, hl, 32'(in_b), 32'(limit_b));
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Continuous compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_on) begin
      check("model_out_a",  32'(out_a),  32'(m_a.out));
      check("model_idx_a",  32'(idx_a),  32'(m_a.idx));
      check("model_wrap_a", 32'(wrap_a), 32'(m_a.wrap));
      check("model_out_b",  32'(out_b),  32'(m_b.out));
      check("model_idx_b",  32'(idx_b),  32'(m_b.idx));
      check("model_wrap_b", 32'(wrap_b), 32'(m_b.wrap));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int exp_out_a [13] = '{1, 1, 1, 2, 2, 2, 4, 4, 4, 8, 8, 8, 1};
  int exp_idx_a [13] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};

  initial begin
    // Power-on reset, then release into IDLE with active-low polarity.
    tick();
    tick();
    chk_on = 1'b1;
    check("rst_out", 32'(out_a), 0);
    check("rst_idx", 32'(idx_a), 0);
    rst_n = 1'b1;
    tick();
    check("idle_out_low", 32'(out_a), 32'hF);
    check("idle_wrap", 32'(wrap_a), 0);

    // Direct decode, then polarity flip.
    en = 1'b1; mode = 1'b0; hl = 1'b1; in_a = 2'd2;
    tick();
    check("dir_out", 32'(out_a), 32'h4);
    check("dir_idx", 32'(idx_a), 2);
    hl = 1'b0;
    tick();
    check("dir_out_low", 32'(out_a), 32'hB);

    // Full scan on A (dwell 3, limit 3) alongside a short scan on B (dwell 1, limit 2).
    hl = 1'b1; mode = 1'b1; limit_a = 2'd3; limit_b = 3'd2;
    for (int k = 0; k < 13; k++) begin
      tick();
      check("scan_out_a",  32'(out_a),  32'(exp_out_a[k]));
      check("scan_idx_a",  32'(idx_a),  32'(exp_idx_a[k]));
      check("scan_wrap_a", 32'(wrap_a), (k == 12) ? 1 : 0);
      check("scan_idx_b",  32'(idx_b),  32'(k % 3));
      check("scan_wrap_b", 32'(wrap_b), (k != 0 && (k % 3) == 0) ? 1 : 0);
      check("scan_hi_b",   32'(out_b[7:3]), 0);
    end

    // Mode and enable switching from the middle of a scan.
    mode = 1'b0;
    tick();
    mode = 1'b1;
    repeat (7) tick();
    check("sw_scan_idx", 32'(idx_a), 2);
    check("sw_scan_out", 32'(out_a), 32'h4);
    mode = 1'b0; in_a = 2'd1;
    tick();
    check("sw_dir_out", 32'(out_a), 32'h2);
    mode = 1'b1;
    tick();
    check("sw_entry_idx", 32'(idx_a), 0);
    check("sw_entry_out", 32'(out_a), 32'h1);
    check("sw_entry_wrap", 32'(wrap_a), 0);
    mode = 1'b0; in_a = 2'd3;
    tick();
    en = 1'b0;
    tick();
    check("sw_idle_out", 32'(out_a), 0);
    check("sw_idle_idx", 32'(idx_a), 3);
    hl = 1'b0;
    tick();
    check("sw_idle_out_low", 32'(out_a), 32'hF);
    check("sw_idle_idx2", 32'(idx_a), 3);

    // Lower the limit while sitting on index 3.
    en = 1'b1; hl = 1'b1; mode = 1'b1; limit_a = 2'd3;
    repeat (10) tick();
    check("ld_idx3", 32'(idx_a), 3);
    check("ld_out3", 32'(out_a), 32'h8);
    limit_a = 2'd1;
    repeat (3) tick();
    check("ld_wrap_idx", 32'(idx_a), 0);
    check("ld_wrap", 32'(wrap_a), 1);
    for (int k = 0; k < 8; k++) begin
      tick();
      check("ld_hi_bits", 32'(out_a[3:2]), 0);
    end

    // Asynchronous reset in the middle of a scan.
    rst_n = 1'b0;
    #1;
    check("mid_rst_out", 32'(out_a), 0);
    check("mid_rst_idx", 32'(idx_a), 0);
    check("mid_rst_wrap", 32'(wrap_a), 0);
    en = 1'b0; hl = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_out", 32'(out_a), 32'hF);
    en = 1'b1; hl = 1'b1; mode = 1'b1;
    tick();
    check("restart_out", 32'(out_a), 32'h1);

    // Randomized traffic checked by the model compare process.
    for (int c = 0; c < 3000; c++) begin
      en = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 19) == 0) mode = ~mode;
      if ($urandom_range(0, 29) == 0) hl = ~hl;
      in_a = 2'($urandom);
      in_b = 3'($urandom);
      if ($urandom_range(0, 14) == 0) limit_a = 2'($urandom);
      if ($urandom_range(0, 14) == 0) limit_b = 3'($urandom);
      if ($urandom_range(0, 399) == 0) begin
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
      end
      tick();
    end

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/scan_decoder.md
SCAN_DECODER -- requirements
Module: scan_decoder

Interface
REQ-001 Parameter N, default 2: select/index width; OUT width is 2**N; legal range 1..6.
REQ-002 Parameter PRESC, default 4: scan dwell in CLK cycles per output; legal range 1..65535.
REQ-003 CLK  input  1  single clock, rising-edge.
REQ-004 RST_N  input  1  reset, asynchronous, active-low.
REQ-005 EN  input  1  enable; 0 forces all outputs inactive.
REQ-006 HL  input  1  output polarity; 1 = active-high one-hot, 0 = active-low one-cold.
REQ-007 MODE  input  1  0 = DIRECT (decode IN), 1 = SCAN (decode internal index).
REQ-008 IN  input  N  binary select used in DIRECT.
REQ-009 LIMIT  input  N  last index of the scan sequence in SCAN.
REQ-010 OUT  output  2**N  registered decoded outputs.
REQ-011 IDX  output  N  registered index currently driven on OUT.
REQ-012 WRAP  output  1  one-cycle pulse when the scan index returns to 0.

Function
REQ-013 FSM states IDLE, DIRECT, SCAN; every state is re-evaluated each cycle: EN=0 -> IDLE; EN=1,MODE=0 -> DIRECT; EN=1,MODE=1 -> SCAN.
REQ-014 IDLE: next-cycle OUT = all bits at the inactive level (all 0 if HL=1, all 1 if HL=0); IDX holds; prescaler cleared; WRAP=0.
REQ-015 DIRECT: latency 1 cycle; OUT bit IN is active, all other bits inactive; IDX = IN; prescaler cleared; WRAP=0.
REQ-016 SCAN: prescaler counts 0..PRESC-1; on terminal count (PRESC-1), prescaler returns to 0 and the scan index advances.
REQ-017 Index advance: if IDX >= LIMIT, IDX becomes 0 and WRAP pulses for exactly that cycle; otherwise IDX = IDX+1.
REQ-018 SCAN: OUT always decodes the registered IDX at the HL polarity; each index is held for exactly PRESC cycles.
REQ-019 PRESC=1: index advances every cycle; LIMIT=0: IDX stays 0 and WRAP pulses on every terminal count.
REQ-020 LIMIT lowered below the current IDX mid-scan: next advance wraps to 0 (per REQ-017); no out-of-range index is driven.
REQ-021 Entry into SCAN from IDLE or DIRECT: IDX forced to 0, prescaler cleared, OUT decodes index 0 on the entry cycle; WRAP=0 on entry.
REQ-022 HL change takes effect on the next clock edge without disturbing IDX or the prescaler.
REQ-023 Exactly one OUT bit is active in DIRECT and SCAN; none in IDLE.
REQ-024 Index arithmetic is N-bit unsigned; prescaler width is clog2(PRESC) (minimum 1 bit).

Reset
REQ-025 RST_N low asynchronously sets OUT=0, IDX=0, WRAP=0, prescaler=0, state=IDLE.
REQ-026 On the first clock edge after RST_N deasserts, the state and outputs follow REQ-013..REQ-015 using the current EN, MODE and HL.
REQ-027 Reset asserted mid-scan aborts the scan immediately; the scan restarts at index 0 per REQ-021.

Structure
REQ-028 Package scan_decoder_pkg SHALL hold the state type (IDLE, DIRECT, SCAN), the mode constants (MODE_DIRECT=0, MODE_SCAN=1) and the prescaler-width function.
REQ-029 One combinational sub-module, onehot_dec (N-bit binary in, enable, HL -> 2**N out), SHALL be shared by the DIRECT and SCAN paths; all registers reside in scan_decoder.

Verification
REQ-030 Reset/IDLE: N=2, assert RST_N=0 mid-run -> OUT=0000, IDX=0, WRAP=0 immediately; release with EN=0, HL=0 -> OUT=1111 after 1 edge.
REQ-031 DIRECT: N=2, EN=1, MODE=0, HL=1, IN=2 -> OUT=0100 after 1 edge; HL=0 -> OUT=1011 after next edge.
REQ-032 SCAN full cycle: N=2, PRESC=3, LIMIT=3, HL=1 -> OUT 0001,0010,0100,1000, each held for 3 cycles; WRAP is a 1-cycle pulse as IDX goes 3->0.
REQ-033 Short scan: N=3, PRESC=1, LIMIT=2 -> IDX 0,1,2,0,... every cycle; WRAP is high every third cycle; OUT bits 3..7 are never active.
REQ-034 LIMIT drop: IDX=3 with LIMIT changed 3->1 -> next advance gives IDX=0 with WRAP=1; no OUT bit above 1 is active afterward.
REQ-035 Mode/enable switching: SCAN at IDX=2 -> MODE=0 with IN=1 gives OUT=0010; MODE=1 again gives IDX=0 and OUT=0001 on the entry cycle; EN=0 gives OUT=0000 and IDX held.
